// File: rtl/data_memory_pkg.sv
// Shared types and default parameters for the data memory controller.
package data_memory_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_ADDR_W     = 8;
   localparam int unsigned DEF_DEPTH      = 256;
   localparam int unsigned DEF_INIT_VAL   = 0;
   localparam bit          DEF_READ_FIRST = 1'b1;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one synchronous read port.
// A same-address read and write in one cycle returns the old word.
module mem_array
   import data_memory_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Callers only enable ports for in-range addresses.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[IDX_W'(wr_addr)] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[IDX_W'(rd_addr)];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port request/response memory controller with a power-on init sweep
// and a fixed one-cycle response latency.
module data_memory_ctrl
   import data_memory_pkg::*;
#(
   parameter int unsigned       DATA_W     = DEF_DATA_W,
   parameter int unsigned       ADDR_W     = DEF_ADDR_W,
   parameter int unsigned       DEPTH      = DEF_DEPTH,
   parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(DEF_INIT_VAL),
   parameter bit                READ_FIRST = DEF_READ_FIRST
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              init_busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              use_mem_q, use_mem_d;
   logic [DATA_W-1:0] rsp_wdata_q, rsp_wdata_d;

   logic              accept_c;
   logic              in_range_c;
   logic              mem_we_c;
   logic              mem_re_c;
   logic [ADDR_W-1:0] mem_waddr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic [DATA_W-1:0] mem_rdata;

   // Next state, sweep counter, write-port mux and response staging.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_we_c    = 1'b0;
      mem_re_c    = 1'b0;
      mem_waddr_c = req_addr;
      mem_wdata_c = req_wdata;
      in_range_c  = ({1'b0, req_addr} < DEPTH_X);
      accept_c    = req_valid && ready_q;

      unique case (state_q)
         INIT: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            mem_wdata_c = INIT_VAL;
            cnt_d       = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            mem_we_c = accept_c && in_range_c && req_write;
            mem_re_c = accept_c && in_range_c && (!req_write || READ_FIRST);
         end
      endcase

      ready_d     = (state_d == RUN);
      busy_d      = (state_d == INIT);
      rsp_valid_d = accept_c;
      rsp_err_d   = accept_c && !in_range_c;
      use_mem_d   = mem_re_c;
      // Error and idle responses leave both data sources at zero.
      rsp_wdata_d = (accept_c && in_range_c && req_write) ? req_wdata : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         use_mem_q   <= 1'b0;
         rsp_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         use_mem_q   <= use_mem_d;
         rsp_wdata_q <= rsp_wdata_d;
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clock   (clock),
      .wr_en   (mem_we_c),
      .wr_addr (mem_waddr_c),
      .wr_data (mem_wdata_c),
      .rd_en   (mem_re_c),
      .rd_addr (req_addr),
      .rd_data (mem_rdata)
   );

   assign req_ready = ready_q;
   assign init_busy = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data  = use_mem_q ? mem_rdata : rsp_wdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Three controller variants share one request stream; responses are compared
// against per-variant tables and a behavioural memory model.
module tb_data_memory_ctrl;

   localparam int NI = 3;
   // u0: defaults; u1: write-first, INIT_VAL A5; u2: DEPTH 200
   localparam int       DEP0 = 256;
   localparam int       DEP1 = 256;
   localparam int       DEP2 = 200;
   localparam bit       RF0  = 1'b1;
   localparam bit       RF1  = 1'b0;
   localparam bit       RF2  = 1'b1;
   localparam bit [7:0] IV0  = 8'h00;
   localparam bit [7:0] IV1  = 8'hA5;
   localparam bit [7:0] IV2  = 8'h00;

   logic       clock;
   logic       reset;
   logic       req_valid;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       req_ready_o [NI];
   logic       rsp_valid_o [NI];
   logic       rsp_err_o   [NI];
   logic       init_busy_o [NI];
   logic [7:0] rsp_data_o  [NI];

   int n_checks;
   int n_pass;
   logic [7:0] mdl [NI][256];

   typedef struct packed {
      logic            wr;
      logic [7:0]      addr;
      logic [7:0]      wdata;
      logic [2:0][7:0] d;
      logic [2:0]      e;
   } vec_t;
   vec_t tbl[$];

   data_memory_ctrl u0 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[0]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_o[0]), .rsp_data(rsp_data_o[0]), .rsp_err(rsp_err_o[0]),
      .init_busy(init_busy_o[0])
   );

   data_memory_ctrl #(.DEPTH(DEP1), .READ_FIRST(RF1), .INIT_VAL(IV1)) u1 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[1]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_o[1]), .rsp_data(rsp_data_o[1]), .rsp_err(rsp_err_o[1]),
      .init_busy(init_busy_o[1])
   );

   data_memory_ctrl #(.DEPTH(DEP2), .READ_FIRST(RF2), .INIT_VAL(IV2)) u2 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_o[2]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_o[2]), .rsp_data(rsp_data_o[2]), .rsp_err(rsp_err_o[2]),
      .init_busy(init_busy_o[2])
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   function automatic int dep(input int k);
      return (k == 0) ? DEP0 : (k == 1) ? DEP1 : DEP2;
   endfunction

   function automatic bit rf(input int k);
      return (k == 0) ? RF0 : (k == 1) ? RF1 : RF2;
   endfunction

   function automatic logic [7:0] iv(input int k);
      return (k == 0) ? IV0 : (k == 1) ? IV1 : IV2;
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s u%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
   endtask

   task automatic chk_rsp(input string name, input int k, input logic v, input logic [7:0] d, input logic e);
      chk({name, "_valid"}, k, 32'(rsp_valid_o[k]), 32'(v));
      chk({name, "_data"},  k, 32'(rsp_data_o[k]),  32'(d));
      chk({name, "_err"},   k, 32'(rsp_err_o[k]),   32'(e));
   endtask

   task automatic chk_reset_state(input string name);
      for (int k = 0; k < NI; k++) begin
         chk_rsp(name, k, 1'b0, 8'h00, 1'b0);
         chk({name, "_ready"}, k, 32'(req_ready_o[k]), 32'd0);
         chk({name, "_busy"},  k, 32'(init_busy_o[k]), 32'd1);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [7:0] wd);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = wd;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference behaviour of one accepted request; updates the model memory.
   function automatic void model_req(input int k, input logic w, input logic [7:0] a,
                                     input logic [7:0] wd, output logic [7:0] d, output logic e);
      if (int'(a) >= dep(k)) begin
         d = 8'h00;
         e = 1'b1;
      end else begin
         e = 1'b0;
         d = (w && !rf(k)) ? wd : mdl[k][a];
         if (w) mdl[k][a] = wd;
      end
   endfunction

   task automatic reinit_model();
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < 256; a++)
            mdl[k][a] = iv(k);
   endtask

   // Releases reset, counts busy cycles per variant; optionally streams reads of
   // address 5 and checks nothing is answered until the sweep has finished.
   task automatic sweep(input bit with_reqs);
      int cnt [NI];
      bit was_busy [NI];
      drive(with_reqs, 1'b0, 8'd5, 8'd0);
      reset = 1'b0;
      for (int k = 0; k < NI; k++) cnt[k] = 0;
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < NI; k++) begin
            was_busy[k] = init_busy_o[k];
            if (init_busy_o[k]) cnt[k]++;
         end
         tick();
         if (with_reqs) begin
            for (int k = 0; k < NI; k++) begin
               if (was_busy[k]) chk("init_no_rsp", k, 32'(rsp_valid_o[k]), 32'd0);
               else chk_rsp("post_init", k, 1'b1, iv(k), 1'b0);
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         chk("busy_cycles", k, 32'(cnt[k]), 32'(dep(k)));
         chk("run_ready", k, 32'(req_ready_o[k]), 32'd1);
         chk("run_busy",  k, 32'(init_busy_o[k]), 32'd0);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
   endtask

   task automatic rand_phase(input int n);
      logic [7:0] ed [NI];
      logic       ee [NI];
      logic       v, w;
      logic [7:0] a, wd;
      for (int i = 0; i < n; i++) begin
         v  = ($urandom_range(0, 9) < 7);
         w  = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(196, 203)) : 8'($urandom_range(0, 255));
         wd = 8'($urandom);
         drive(v, w, a, wd);
         for (int k = 0; k < NI; k++) begin
            if (v) model_req(k, w, a, wd, ed[k], ee[k]);
            else begin
               ed[k] = 8'h00;
               ee[k] = 1'b0;
            end
         end
         tick();
         for (int k = 0; k < NI; k++) chk_rsp("rand", k, v, ed[k], ee[k]);
      end
   endtask

   task automatic add(input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic e0, input logic e1, input logic e2);
      vec_t v;
      v.wr = w; v.addr = a; v.wdata = wd;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
      tbl.push_back(v);
   endtask

   initial begin
      logic [7:0] dd;
      logic       de;
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b0;
      drive(1'b0, 1'b0, 8'd0, 8'd0);

      // Asynchronous reset before any clock edge
      #1 reset = 1'b1;
      #2;
      chk_reset_state("por");
      tick();
      tick();
      sweep(1'b0);
      reinit_model();

      //      wr    addr    wdata   u0     u1     u2     e0 e1 e2
      add(1'b0, 8'd37,  8'd0,   8'h00, 8'hA5, 8'h00, 0, 0, 0);
      add(1'b1, 8'd100, 8'd200, 8'h00, 8'hC8, 8'h00, 0, 0, 0);
      add(1'b1, 8'd101, 8'd7,   8'h00, 8'h07, 8'h00, 0, 0, 0);
      add(1'b0, 8'd100, 8'd0,   8'hC8, 8'hC8, 8'hC8, 0, 0, 0);
      add(1'b0, 8'd101, 8'd0,   8'h07, 8'h07, 8'h07, 0, 0, 0);
      add(1'b1, 8'd103, 8'd200, 8'h00, 8'hC8, 8'h00, 0, 0, 0);
      add(1'b1, 8'd103, 8'd9,   8'hC8, 8'h09, 8'hC8, 0, 0, 0);
      add(1'b1, 8'd250, 8'd55,  8'h00, 8'h37, 8'h00, 0, 0, 1);
      add(1'b0, 8'd250, 8'd0,   8'h37, 8'h37, 8'h00, 0, 0, 1);
      add(1'b0, 8'd199, 8'd0,   8'h00, 8'hA5, 8'h00, 0, 0, 0);
      add(1'b0, 8'd0,   8'd0,   8'h00, 8'hA5, 8'h00, 0, 0, 0);
      add(1'b0, 8'd255, 8'd0,   8'h00, 8'hA5, 8'h00, 0, 0, 1);
      add(1'b1, 8'd0,   8'h3C,  8'h00, 8'h3C, 8'h00, 0, 0, 0);
      add(1'b0, 8'd0,   8'd0,   8'h3C, 8'h3C, 8'h3C, 0, 0, 0);

      // Back-to-back, one request per cycle
      for (int i = 0; i < tbl.size(); i++) begin
         drive(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
         for (int k = 0; k < NI; k++) model_req(k, tbl[i].wr, tbl[i].addr, tbl[i].wdata, dd, de);
         tick();
         for (int k = 0; k < NI; k++) chk_rsp("tbl", k, 1'b1, tbl[i].d[k], tbl[i].e[k]);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      for (int k = 0; k < NI; k++) chk_rsp("idle", k, 1'b0, 8'h00, 1'b0);

      rand_phase(400);

      // Reset while a response is on the outputs drops it immediately
      drive(1'b1, 1'b0, 8'd1, 8'd0);
      tick();
      for (int k = 0; k < NI; k++) chk("inflight_valid", k, 32'(rsp_valid_o[k]), 32'd1);
      reset = 1'b1;
      #2;
      chk_reset_state("rst_run");
      reset = 1'b0;

      // Requests during the sweep are ignored
      for (int n = 0; n < 50; n++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom));
         tick();
         for (int k = 0; k < NI; k++) chk("sweep_ignore", k, 32'(rsp_valid_o[k]), 32'd0);
      end
      for (int k = 0; k < NI; k++) begin
         chk("mid_sweep_busy",  k, 32'(init_busy_o[k]), 32'd1);
         chk("mid_sweep_ready", k, 32'(req_ready_o[k]), 32'd0);
      end

      // Reset at sweep address 50 restarts the full sweep
      reset = 1'b1;
      #2;
      chk_reset_state("rst_init");
      sweep(1'b1);
      reinit_model();
      rand_phase(150);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter INIT_VAL, default 0, DATA_W-bit value written to every word by the init sweep.
REQ-005 Parameter READ_FIRST, default 1; 1 = write response returns old word, 0 = returns new word.
REQ-006 clock  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  one-cycle response pulse.
REQ-014 rsp_data  output  DATA_W  response data.
REQ-015 rsp_err  output  1  out-of-range address flag, qualified by rsp_valid.
REQ-016 init_busy  output  1  init sweep in progress.

Function
REQ-017 States SHALL be INIT and RUN; reset enters INIT.
REQ-018 INIT: one word per cycle written with INIT_VAL, addresses 0..DEPTH-1 ascending, counter-driven; after writing DEPTH-1, next cycle enters RUN; sweep takes exactly DEPTH cycles.
REQ-019 init_busy = 1 and req_ready = 0 throughout INIT; in RUN init_busy = 0 and req_ready = 1 every cycle.
REQ-020 Request accepted on rising edge when req_valid && req_ready; requests in INIT are ignored, no response.
REQ-021 Latency fixed at 1: accepted in cycle N -> rsp_valid = 1 in cycle N+1 only; one request per cycle sustained, no response backpressure.
REQ-022 Read: rsp_data = word[req_addr] as of cycle N, rsp_err = 0.
REQ-023 Write: word[req_addr] <= req_wdata at end of cycle N; rsp_data = old word if READ_FIRST=1, else req_wdata; rsp_err = 0.
REQ-024 req_addr >= DEPTH: no memory change, rsp_valid = 1, rsp_err = 1, rsp_data = 0.
REQ-025 Write in cycle N followed by read of same address in N+1 SHALL return the written data.
REQ-026 When rsp_valid = 0, rsp_data and rsp_err SHALL hold 0.
REQ-027 Address compare SHALL use ADDR_W+1-bit arithmetic so DEPTH = 2**ADDR_W never flags errors.

Reset
REQ-028 On reset assertion, immediately: rsp_valid = 0, rsp_data = 0, rsp_err = 0, req_ready = 0, init_busy = 1, init counter = 0, state = INIT.
REQ-029 Reset mid-INIT or mid-RUN SHALL restart the full sweep from address 0; any in-flight response is dropped.
REQ-030 Memory array itself SHALL NOT be on reset; contents defined only by the sweep.

Structure
REQ-031 Package data_memory_pkg SHALL hold the state enum (INIT, RUN) and default parameter constants.
REQ-032 Storage SHALL be sub-module mem_array: DEPTH x DATA_W, one synchronous write port, one synchronous read port, read-before-write on same address.
REQ-033 data_memory_ctrl SHALL contain FSM, init counter, write-port mux (sweep vs request), range check and response registers.

Verification
REQ-034 Reset, count cycles with DEFAULTS -> init_busy high exactly 256 cycles, then req_ready = 1; read addr 37 -> rsp_data = 0.
REQ-035 Write 200 to 100, write 7 to 101, read 100, read 101 back-to-back -> responses 0, 0, 200, 7 (READ_FIRST=1), rsp_valid every cycle.
REQ-036 READ_FIRST=0: write 9 to 103 -> rsp_data = 9; READ_FIRST=1 with prior 200 at 103 -> rsp_data = 200.
REQ-037 DEPTH=200: write 55 to 250 -> rsp_err = 1, rsp_data = 0; read 250 -> rsp_err = 1; read 199 -> rsp_err = 0.
REQ-038 Assert reset at sweep address 50, release -> sweep restarts at 0, init_busy high DEPTH further cycles; requests during INIT produce no rsp_valid.
REQ-039 INIT_VAL = 8'hA5: after sweep read 0 and 255 -> both 8'hA5.
